pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch stage directly upstream of the PC adder and the decode path. It owns the architectural program counter, issues one instruction-memory request at a time over a request/ready + rvalid handshake, and computes the sequential next PC. It also redirects the PC on taken branches and gives the shared memory bus to the DMA engine between fetches.

## Interface
Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- INSTR_BYTES, 4, sequential PC increment.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  downstream not ready; holds the issued instruction and blocks new fetches.
- branch_taken  in  1  one-cycle redirect strobe.
- branch_target  in  ADDR_W  redirect address.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address, equal to pc.
- imem_ready  in  1  memory accepted the request.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  DATA_W  read data.
- instr_valid  out  1  instr/instr_pc are valid.
- instr  out  DATA_W  fetched instruction.
- instr_pc  out  ADDR_W  address of instr; feeds the PC adder operand.
- pc  out  ADDR_W  current fetch PC.
- misalign  out  1  one-cycle pulse: branch_target[1:0] != 0.
- dma_req  in  1  DMA requests the bus.
- dma_gnt  out  1  bus granted to DMA.

## Operation
- FSM states: IDLE, FETCH, WAIT, DMA_HOLD.
- IDLE → FETCH after one cycle, or → DMA_HOLD if dma_req=1.
- FETCH drives imem_req=1 and imem_addr=pc. When imem_ready=1, go to WAIT.
- WAIT:
  - On imem_rvalid=1, latch instr=imem_rdata and instr_pc=pc, set instr_valid=1, and set pc=pc+INSTR_BYTES.
  - Next state: DMA_HOLD if dma_req=1; else FETCH if stall=0; else IDLE.
- DMA_HOLD: dma_gnt=1 and imem_req=0. When dma_req=0, go to FETCH on the next cycle.
- stall=1 with instr_valid=1: instr, instr_pc and instr_valid hold. No new request is issued until stall=0.
- instr_valid clears on the first cycle with stall=0 unless a new rvalid arrives in that cycle.
- branch_taken (takes priority over sequential update):
  - pc ← {branch_target[ADDR_W-1:2],2'b00}; instr_valid ← 0.
  - In WAIT, the outstanding response is squashed: the next imem_rvalid is discarded, then the FSM goes to FETCH at the target.
  - In FETCH before acceptance, the request address switches to the target the next cycle.
- Arithmetic: pc+INSTR_BYTES is modulo 2^ADDR_W. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Only one request is outstanding. imem_rvalid outside WAIT is ignored.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, misalign=0, dma_gnt=0.
- First imem_req goes high in the 2nd cycle after rst_n deasserts.
- With zero-wait memory (ready in the request cycle, rvalid the next cycle), instr_valid rises 2 cycles after imem_req.
- Sustained throughput without stall or DMA: one instruction per 2 cycles.
- branch_taken in cycle N: imem_addr equals the target in cycle N+1, or after the squashed response.
- dma_gnt rises one cycle after entry to DMA_HOLD is decided and falls the cycle after dma_req drops. Grant is never given while a request is outstanding (FETCH or WAIT).
- Reset mid-operation: all state clears immediately (async). Any in-flight memory response after reset is ignored.

## Configuration
- PC_FETCH_DMA_ARB_EN defined: DMA_HOLD and the dma_req/dma_gnt arbitration are compiled in as described above.
- PC_FETCH_DMA_ARB_EN not defined:
  - dma_gnt tied 0, dma_req ignored, DMA_HOLD absent.
  - WAIT goes to FETCH (or IDLE when stalled).

## Structure
- pc_fetch_pkg:
  - FSM state enum.
  - INSTR_BYTES.
  - default RESET_PC.
  - squash-flag encoding.
- Sub-module pc_next_sel: combinational next-PC mux over branch target (aligned), pc+INSTR_BYTES, and hold, plus misalign detection. The FSM and registers stay in pc_fetch.

## Test plan
- Reset release, RESET_PC=0, memory returns 0x11,0x22,0x33 with zero wait → instr_pc 0x0,0x4,0x8 with matching instr; first imem_req in the 2nd cycle.
- pc=0xFFFF_FFFC fetch → next imem_addr 0x0000_0000.
- branch_taken with target 0x100 while in WAIT → stale rvalid discarded, instr_valid stays 0 for it, next imem_addr=0x100.
- branch_target 0x102 → misalign pulses 1 cycle, fetch from 0x100.
- stall=1 for 5 cycles after instr_valid → instr held, imem_req=0 throughout, fetch resumes the cycle after stall drops.
- dma_req asserted during WAIT → dma_gnt only after rvalid; dma_gnt=1 for 4 cycles with imem_req=0; with macro undefined, dma_gnt stays 0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// pc_fetch shared types and constants.
// FSM state codes, fetch step, reset PC and squash flag values.
package pc_fetch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FETCH = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_DMA   = 2'd3;

  localparam int INSTR_BYTES = 4;

  localparam logic [31:0] RESET_PC_DEFAULT =
    32'h0000_0000;

  localparam logic SQ_NONE = 1'b0;
  localparam logic SQ_PEND = 1'b1;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/ready + rvalid bus.
// master = fetch stage, slave = memory.
interface pc_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import pc_fetch_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, addr,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, addr,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC select: aligned branch target, sequential
// increment or hold, plus branch target misalign detect.
module pc_next_sel #(
  parameter int ADDR_W      = 32,
  parameter int INSTR_BYTES = 4
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc_next,
  output logic              misalign
);
  import pc_fetch_pkg::*;

  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] seq;

  assign tgt = {branch_target[ADDR_W-1:2], 2'b00};
  assign seq = pc + ADDR_W'(INSTR_BYTES);

  assign misalign = branch_taken &&
                    (branch_target[1:0] != 2'b00);

  always_comb begin
    pc_next = pc;
    unique case (1'b1)
      branch_taken:            pc_next = tgt;
      (!branch_taken&&advance): pc_next = seq;
      default:                 pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC, single-outstanding fetch,
// redirect/squash. DMA bus arbitration: PC_FETCH_DMA_ARB_EN.
module pc_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(pc_fetch_pkg::RESET_PC_DEFAULT),
  parameter int INSTR_BYTES = pc_fetch_pkg::INSTR_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  pc_fetch_if.master        imem,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              misalign,
  input  logic              dma_req,
  output logic              dma_gnt
);
  import pc_fetch_pkg::*;

  state_t            state, state_nx;
  logic              squash, squash_nx;
  logic              hold, fire, take;
  logic              drop, adv, dma_on;
  logic              mis_nx;
  logic [ADDR_W-1:0] pc_nx;

`ifdef PC_FETCH_DMA_ARB_EN
  assign dma_on = dma_req;
`else
  logic unused_dma;
  assign unused_dma = dma_req;
  assign dma_on     = 1'b0;
`endif

  // never overwrite an instruction held for a stalled consumer
  assign hold      = stall && instr_valid;
  assign imem.req  = (state == S_FETCH) && !hold;
  assign imem.addr = pc;

  assign fire = imem.req && imem.ready;
  assign take = (state == S_WAIT) && imem.rvalid;
  assign drop = take &&
                ((squash == SQ_PEND) || branch_taken);
  assign adv  = take && !drop;

  pc_next_sel #(
    .ADDR_W      (ADDR_W),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .advance       (adv),
    .pc_next       (pc_nx),
    .misalign      (mis_nx)
  );

  always_comb begin
    state_nx  = state;
    squash_nx = squash;
    unique case (state)
      S_IDLE: begin
        if (dma_on)      state_nx = S_DMA;
        else if (!stall) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (fire) begin
          state_nx = S_WAIT;
          if (branch_taken) squash_nx = SQ_PEND;
        end
      end
      S_WAIT: begin
        if (take) begin
          squash_nx = SQ_NONE;
          if (drop)        state_nx = S_FETCH;
          else if (dma_on) state_nx = S_DMA;
          else if (!stall) state_nx = S_FETCH;
          else             state_nx = S_IDLE;
        end else if (branch_taken) begin
          squash_nx = SQ_PEND;
        end
      end
`ifdef PC_FETCH_DMA_ARB_EN
      S_DMA: begin
        if (!dma_req) state_nx = S_FETCH;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      squash      <= SQ_NONE;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      misalign    <= 1'b0;
    end else begin
      state    <= state_nx;
      squash   <= squash_nx;
      pc       <= pc_nx;
      misalign <= mis_nx;
      if (adv) begin
        instr    <= imem.rdata;
        instr_pc <= pc;
      end
      if (branch_taken) instr_valid <= 1'b0;
      else if (adv)     instr_valid <= 1'b1;
      else if (!stall)  instr_valid <= 1'b0;
    end
  end

`ifdef PC_FETCH_DMA_ARB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dma_gnt <= 1'b0;
    else        dma_gnt <= (state_nx == S_DMA);
  end
`else
  assign dma_gnt = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: vector table,
// directed corner sequences, randomized scoreboard run.
module tb_pc_fetch;

  typedef struct {
    logic        st;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ins;
    logic [31:0] ipc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        dma_req = 1'b0;
  logic        instr_valid, misalign, dma_gnt;
  logic [31:0] instr, instr_pc, pc;

  int          n_chk = 0;
  int          n_fail = 0;

  int          rdy_mode = 0;
  int          lat = 0;
  int          lat_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  vec_t        tbl [14];
  logic [31:0] exp_pc, tgt;
  logic        br, dma_build;
  int          ndel, ngnt;

  pc_fetch_if bus ();

  pc_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc            (pc),
    .misalign      (misalign),
    .dma_req       (dma_req),
    .dma_gnt       (dma_gnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(
    input logic [31:0] a);
    return 32'h11 * ((a >> 2) + 32'd1);
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_req"}, 32'(bus.req), 0);
    chk({tag, "_valid"}, 32'(instr_valid), 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_ipc"}, instr_pc, 0);
    chk({tag, "_mis"}, 32'(misalign), 0);
    chk({tag, "_gnt"}, 32'(dma_gnt), 0);
  endtask

  // one clock: drive at negedge, memory responds,
  // return #1 after the rising edge
  task automatic step(input logic st, input logic b,
                      input logic [31:0] t,
                      input logic dr);
    @(negedge clk);
    stall = st;
    branch_taken = b;
    branch_target = t;
    dma_req = dr;
    bus.rvalid = 1'b0;
    if (pend) begin
      if (lat_cnt == 0) begin
        bus.rvalid = 1'b1;
        bus.rdata = mdata(pend_addr);
        pend = 1'b0;
      end else begin
        lat_cnt--;
      end
    end
    case (rdy_mode)
      0: bus.ready = 1'b1;
      1: bus.ready = 1'b0;
      default: bus.ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (bus.req && bus.ready) begin
      pend = 1'b1;
      pend_addr = bus.addr;
      lat_cnt = (rdy_mode == 2) ?
                int'($urandom_range(0, lat)) : lat;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_rst(tag);
    lat_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk({tag, "_req_c1"}, 32'(bus.req), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
`ifdef PC_FETCH_DMA_ARB_EN
    dma_build = 1'b1;
`else
    dma_build = 1'b0;
`endif
    bus.ready = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = '0;

    tbl[0]  = '{0, 1, 32'h00, 0, 32'h00, 32'h0};
    tbl[1]  = '{0, 0, 32'h00, 0, 32'h00, 32'h0};
    tbl[2]  = '{0, 1, 32'h04, 1, 32'h11, 32'h0};
    tbl[3]  = '{0, 0, 32'h04, 0, 32'h00, 32'h0};
    tbl[4]  = '{0, 1, 32'h08, 1, 32'h22, 32'h4};
    tbl[5]  = '{0, 0, 32'h08, 0, 32'h00, 32'h0};
    tbl[6]  = '{1, 0, 32'h0c, 1, 32'h33, 32'h8};
    tbl[7]  = '{1, 0, 32'h0c, 1, 32'h33, 32'h8};
    tbl[8]  = '{1, 0, 32'h0c, 1, 32'h33, 32'h8};
    tbl[9]  = '{1, 0, 32'h0c, 1, 32'h33, 32'h8};
    tbl[10] = '{1, 0, 32'h0c, 1, 32'h33, 32'h8};
    tbl[11] = '{0, 1, 32'h0c, 0, 32'h00, 32'h0};
    tbl[12] = '{0, 0, 32'h0c, 0, 32'h00, 32'h0};
    tbl[13] = '{0, 1, 32'h10, 1, 32'h44, 32'hc};

    #2;
    apply_reset("rst");

    rdy_mode = 0;
    lat = 0;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].st, 1'b0, 32'h0, 1'b0);
      chk($sformatf("v%0d_req", i),
          32'(bus.req), 32'(tbl[i].req));
      chk($sformatf("v%0d_addr", i),
          bus.addr, tbl[i].addr);
      chk($sformatf("v%0d_valid", i),
          32'(instr_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("v%0d_instr", i),
            instr, tbl[i].ins);
        chk($sformatf("v%0d_ipc", i),
            instr_pc, tbl[i].ipc);
      end
    end

    // redirect to the top word, then wrap
    rdy_mode = 1;
    step(0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_tgt_addr", bus.addr, 32'hFFFF_FFFC);
    chk("wrap_req", 32'(bus.req), 1);
    chk("wrap_valid", 32'(instr_valid), 0);
    chk("wrap_mis", 32'(misalign), 0);
    rdy_mode = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", instr, mdata(32'hFFFF_FFFC));
    chk("wrap_next_addr", bus.addr, 32'h0);

    // redirect while a response is outstanding
    lat = 2;
    step(0, 0, 0, 0);
    chk("sq_wait_req", 32'(bus.req), 0);
    step(0, 1, 32'h100, 0);
    chk("sq_br_valid", 32'(instr_valid), 0);
    chk("sq_br_req", 32'(bus.req), 0);
    lat = 0;
    step(0, 0, 0, 0);
    chk("sq_hold_valid", 32'(instr_valid), 0);
    step(0, 0, 0, 0);
    chk("sq_stale_valid", 32'(instr_valid), 0);
    chk("sq_req", 32'(bus.req), 1);
    chk("sq_addr", bus.addr, 32'h100);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sq_new_valid", 32'(instr_valid), 1);
    chk("sq_new_ipc", instr_pc, 32'h100);
    chk("sq_new_instr", instr, mdata(32'h100));

    // misaligned redirect target
    rdy_mode = 1;
    step(0, 1, 32'h102, 0);
    chk("mis_pulse", 32'(misalign), 1);
    chk("mis_addr", bus.addr, 32'h100);
    step(0, 0, 0, 0);
    chk("mis_clear", 32'(misalign), 0);
    rdy_mode = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("mis_ipc", instr_pc, 32'h100);
    chk("mis_valid", 32'(instr_valid), 1);

    // DMA request arriving during WAIT
    lat = 1;
    ngnt = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("dma_wait_gnt", 32'(dma_gnt), 0);
    chk("dma_wait_req", 32'(bus.req), 0);
    rdy_mode = 1;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1);
      if (dma_gnt) ngnt++;
      chk($sformatf("dma_hold%0d_gnt", k),
          32'(dma_gnt), 32'(dma_build));
      chk($sformatf("dma_hold%0d_req", k),
          32'(bus.req), 32'(!dma_build));
      if (k == 0) begin
        chk("dma_ipc", instr_pc, 32'h104);
        chk("dma_valid", 32'(instr_valid), 1);
      end
    end
    step(0, 0, 0, 0);
    chk("dma_drop_gnt", 32'(dma_gnt), 0);
    chk("dma_drop_req", 32'(bus.req), 1);
    chk("dma_gnt_cycles", ngnt, dma_build ? 4 : 0);

    // reset with a response still in flight
    rdy_mode = 0;
    lat = 3;
    step(0, 0, 0, 0);
    apply_reset("midrst");
    step(0, 0, 0, 0);
    chk("midrst_stale_valid", 32'(instr_valid), 0);
    chk("midrst_req", 32'(bus.req), 1);
    chk("midrst_addr", bus.addr, 32'h0);

    // random latency/ready/redirect run vs. PC model
    rdy_mode = 2;
    lat = 3;
    exp_pc = 32'h0;
    ndel = 0;
    for (int i = 0; i < 3000; i++) begin
      br = ($urandom_range(0, 9) == 0);
      tgt = $urandom;
      if (br) exp_pc = {tgt[31:2], 2'b00};
      step(0, br, tgt, 0);
      chk("rnd_mis", 32'(misalign),
          32'(br && (tgt[1:0] != 2'b00)));
      if (instr_valid) begin
        chk("rnd_ipc", instr_pc, exp_pc);
        chk("rnd_instr", instr, mdata(exp_pc));
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end
    end
    chk("rnd_progress", 32'(ndel > 200), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
